// File: rtl/timing_control_unit.sv
// timing_control_unit: sequence-counter control, fetch/indirect strobes and run/halt flip-flop
module timing_control_unit #(
  parameter int SC_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [SC_WIDTH-1:0]      COUNT,
  input  logic [15:0]              IR,
  input  logic                     START,
  output logic                     SC_INC,
  output logic                     SC_CLR,
  output logic [2**SC_WIDTH-1:0]   T,
  output logic [7:0]               D,
  output logic                     I,
  output logic                     RUN,
  output logic                     AR_LD,
  output logic                     IR_LD,
  output logic                     PC_INC,
  output logic [2:0]               BUS_SEL
);
  localparam int TW = 2**SC_WIDTH;
  logic          r_run;
  logic [7:0]    r_d;
  logic          r_i;
  logic [TW-1:0] w_t;
  logic          w_end;
  logic          w_hlt;
  logic          w_ill;
  logic          w_ind;
  logic          w_unused;
  assign w_unused = ^IR[11:1];
  // decode timing, end-of-instruction, halt and indirect conditions
  always_comb begin
    w_t   = r_run ? TW'(1) << COUNT : '0;
    w_ill = r_run && (COUNT > SC_WIDTH'(6));
    w_end = (w_t[3] & r_d[7])
          | (w_t[5] & (r_d[0] | r_d[1] | r_d[2] | r_d[5]))
          | (w_t[4] & (r_d[3] | r_d[4]))
          | (w_t[6] & r_d[6]);
    w_hlt = w_t[3] & r_d[7] & ~r_i & IR[0];
    w_ind = w_t[3] & ~r_d[7] & r_i;
  end
  // counter controls and fetch/indirect strobes; idle parks the counter at 0
  always_comb begin
    SC_CLR  = ~r_run | w_end | w_ill;
    SC_INC  = r_run & ~SC_CLR;
    AR_LD   = w_t[0] | w_t[2] | w_ind;
    IR_LD   = w_t[1];
    PC_INC  = w_t[1];
    BUS_SEL = w_t[0] ? 3'd2 : w_t[1] ? 3'd7 : w_t[2] ? 3'd5 : w_ind ? 3'd7 : 3'd0;
  end
  // start-stop flip-flop: halt overrides start
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_run <= 1'b0;
    else if (w_hlt) r_run <= 1'b0;
    else if (START && !r_run) r_run <= 1'b1;
  end
  // opcode and indirect bit captured at the end of T2, held until the next T2
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_d <= 8'h00;
      r_i <= 1'b0;
    end else if (w_t[2]) begin
      r_d <= 8'(1) << IR[14:12];
      r_i <= IR[15];
    end
  end
  assign T   = w_t;
  assign D   = r_d;
  assign I   = r_i;
  assign RUN = r_run;
endmodule

// File: tb/tb_timing_control_unit.sv
// tb_timing_control_unit: randomized check of timing_control_unit against an instruction-level model
module tb_timing_control_unit;
  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        START = 1'b0;
  logic [3:0]  COUNT = 4'hF;
  logic [15:0] IR = 16'h0000;
  logic        SC_INC, SC_CLR, I, RUN, AR_LD, IR_LD, PC_INC;
  logic [15:0] T;
  logic [7:0]  D;
  logic [2:0]  BUS_SEL;

  timing_control_unit #(.SC_WIDTH(4)) dut (
    .CLK(CLK), .reset(reset), .COUNT(COUNT), .IR(IR), .START(START),
    .SC_INC(SC_INC), .SC_CLR(SC_CLR), .T(T), .D(D), .I(I), .RUN(RUN),
    .AR_LD(AR_LD), .IR_LD(IR_LD), .PC_INC(PC_INC), .BUS_SEL(BUS_SEL)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int len_tab [8] = '{6, 6, 6, 5, 5, 6, 7, 4};
  logic [15:0] q [$];
  bit m_run = 0, m_dv = 0, m_i = 0, ld_ir = 0;
  int m_op = 0;
  int m_cnt = 15;
  bit e_clr, e_inc, e_ar, e_ir, e_ind, e_hlt;
  logic [2:0] e_bus;
  bit last_clr, last_inc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function void model();
    e_ind = m_run && m_cnt == 3 && m_dv && m_op != 7 && m_i;
    e_clr = !m_run || m_cnt > 6 || (m_dv && m_cnt == len_tab[m_op] - 1);
    e_inc = m_run && !e_clr;
    e_ir  = m_run && m_cnt == 1;
    e_ar  = (m_run && (m_cnt == 0 || m_cnt == 2)) || e_ind;
    e_bus = !m_run ? 3'd0 : m_cnt == 0 ? 3'd2 : m_cnt == 1 ? 3'd7 : m_cnt == 2 ? 3'd5 : e_ind ? 3'd7 : 3'd0;
    e_hlt = m_run && m_cnt == 3 && m_dv && m_op == 7 && !m_i && IR[0];
  endfunction

  task automatic check_all();
    model();
    chk("T", T, m_run ? (32'd1 << m_cnt) : 32'd0);
    chk("SC_CLR", SC_CLR, e_clr);
    chk("SC_INC", SC_INC, e_inc);
    chk("AR_LD", AR_LD, e_ar);
    chk("IR_LD", IR_LD, e_ir);
    chk("PC_INC", PC_INC, e_ir);
    chk("BUS_SEL", BUS_SEL, e_bus);
    chk("RUN", RUN, m_run);
    chk("D", D, m_dv ? (32'd1 << m_op) : 32'd0);
    chk("I", I, m_i);
  endtask

  task automatic step(input bit st);
    bit hlt;
    @(negedge CLK);
    if (ld_ir) begin
      IR = q.size() > 0 ? q.pop_front() : 16'($urandom);
      ld_ir = 0;
    end
    START = st;
    COUNT = 4'(m_cnt);
    #1;
    check_all();
    last_clr = SC_CLR;
    last_inc = SC_INC;
    hlt = e_hlt;
    @(posedge CLK);
    if (m_run && m_cnt == 2) begin
      m_op = int'(IR[14:12]);
      m_i = IR[15];
      m_dv = 1;
    end
    if (m_run && m_cnt == 1) ld_ir = 1;
    m_cnt = e_clr ? 0 : e_inc ? m_cnt + 1 : m_cnt;
    m_run = hlt ? 1'b0 : (st && !m_run) ? 1'b1 : m_run;
  endtask

  task automatic run_instr(input int exp_len, input string tag);
    int n = 0;
    bit done = 0;
    repeat (20) if (!done) begin
      step(0);
      n++;
      done = last_clr;
    end
    chk(tag, n, exp_len);
  endtask

  initial begin
    #1 reset = 1'b1;
    #10;
    check_all();
    @(negedge CLK) reset = 1'b0;
    repeat (3) step(0);
    q.push_back(16'h2123);
    step(1);
    run_instr(6, "len_lda");
    #1;
    chk("D_lda", D, 8'h04);
    chk("I_lda", I, 0);
    q.push_back(16'hE456);
    run_instr(7, "len_isz_ind");
    #1;
    chk("D_isz", D, 8'h40);
    chk("I_isz", I, 1);
    q.push_back(16'h7001);
    run_instr(4, "len_hlt");
    #1;
    chk("hlt_run", RUN, 0);
    repeat (3) step(0);
    q.push_back(16'h7001);
    step(1);
    repeat (3) step(0);
    step(1);
    #1;
    chk("hlt_beats_start", RUN, 0);
    step(1);
    #1;
    chk("start_after_hlt", RUN, 1);
    m_cnt = 10;
    step(0);
    chk("ill_clr", last_clr, 1);
    chk("ill_inc", last_inc, 0);
    q.push_back(16'h3010);
    repeat (4) step(0);
    @(negedge CLK);
    COUNT = 4'd4;
    #1;
    chk("sta_t4", T, 16'h0010);
    reset = 1'b1;
    #1;
    chk("rst_run", RUN, 0);
    chk("rst_d", D, 0);
    chk("rst_i", I, 0);
    chk("rst_t", T, 0);
    chk("rst_clr", SC_CLR, 1);
    m_run = 0; m_dv = 0; m_i = 0; m_op = 0; m_cnt = 15; ld_ir = 0;
    @(negedge CLK) reset = 1'b0;
    repeat (1500) step($urandom_range(0, 3) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/timing_control_unit.md
# timing_control_unit

Control-side partner of the 4-bit sequence counter in the common-bus basic computer. It reads the counter value (COUNT) and the instruction register, and drives the counter's INC/CLR controls back. It sequences fetch, decode, indirect and execute phases, and provides the run/halt start-stop flip-flop. It also publishes the decoded timing (T) and opcode (D) signals that the datapath uses to build its own execution micro-operations.

## Interface
- SC_WIDTH, 4, width of COUNT; T output is 2**SC_WIDTH bits wide.
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- COUNT  in  SC_WIDTH  current sequence-counter value; same clock domain.
- IR  in  16  instruction register contents: IR[15] = I, IR[14:12] = opcode, IR[11:0] = address/function bits.
- START  in  1  level; sets RUN when sampled high.
- SC_INC  out  1  increment request to the sequence counter (combinational).
- SC_CLR  out  1  clear request to the sequence counter (combinational).
- T  out  16  one-hot timing, equal to onehot(COUNT) when RUN=1, otherwise all zero.
- D  out  8  one-hot decoded opcode (registered).
- I  out  1  indirect bit (registered).
- RUN  out  1  start-stop flip-flop S.
- AR_LD, IR_LD, PC_INC  out  1 each  fetch/indirect load strobes (combinational).
- BUS_SEL  out  3  common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.

## Operation
- Registers: RUN, D[7:0], I. Everything else is combinational from COUNT, IR, RUN, D and I.
- Reset values: RUN=0, D=8'h00, I=0. While reset is held, T=0, SC_INC=0, SC_CLR=1, AR_LD=IR_LD=PC_INC=0 and BUS_SEL=0.
- Idle (RUN=0):
  - SC_CLR=1, SC_INC=0, and all strobes are 0.
  - The counter therefore parks at 0; this includes leaving the counter's post-reset value of 4'b1111.
- START: when START=1 and RUN=0 at a clock edge, RUN becomes 1 on that edge. The next cycle is T0. START is ignored while RUN=1.
- Fetch:
  - T0: BUS_SEL=2, AR_LD=1.
  - T1: BUS_SEL=7, IR_LD=1, PC_INC=1.
  - T2: BUS_SEL=5, AR_LD=1. On the edge that ends T2, D is loaded with onehot(IR[14:12]) and I with IR[15].
- T3:
  - D7=0, I=1 (indirect): BUS_SEL=7, AR_LD=1.
  - D7=0, I=0: no strobes.
  - D7=1 (register-reference or I/O): the instruction ends here.
- End of instruction: SC_CLR=1 when one of the following holds, otherwise SC_CLR=0.
  - D7·T3.
  - (D0+D1+D2+D5)·T5 (AND, ADD, LDA, BSA).
  - (D3+D4)·T4 (STA, BUN).
  - D6·T6 (ISZ).
- Illegal count: if COUNT > 6 while RUN=1, SC_CLR=1 to recover to T0.
- SC_INC = RUN & ~SC_CLR. SC_INC and SC_CLR are never both 1.
- HLT: on D7·~I·T3·IR[0], RUN is cleared on that edge and SC_CLR=1.
- HLT and START in the same cycle: HLT wins and RUN ends at 0.
- D and I hold their values from T3 until the next T2 edge. They are not cleared by a halt.
- Execution micro-operations other than the fetch/indirect strobes above are out of scope; the datapath derives them from T, D, I and IR. Interrupt cycle is not supported.

## Timing
- Decode latency: COUNT→T, SC_INC, SC_CLR, strobes and BUS_SEL are combinational, valid in the same cycle for sampling by the counter and registers on the next edge.
- D and I are valid one cycle after T2, i.e. from T3 onward.
- Instruction lengths in cycles, counted from T0 to the SC_CLR cycle inclusive:
  - Register-reference/I/O: 4.
  - STA/BUN: 5.
  - AND/ADD/LDA/BSA: 6.
  - ISZ: 7.
- These lengths are the same for direct and indirect forms.
- Reset asserted mid-instruction: outputs go to reset values immediately (asynchronously). After release, the block idles until START.
- No combinational path from SC_INC/SC_CLR to COUNT inside this block.

## Test plan
- Reset released with COUNT=4'hF, START=0 → SC_CLR=1, SC_INC=0, T=0, RUN=0. The counter settles to 0 and stays there.
- START pulse, then IR=16'h2123 (LDA direct) loaded at T1 → T0..T5 sequence seen. T0: BUS_SEL=2, AR_LD=1. T1: BUS_SEL=7, IR_LD=1, PC_INC=1. T2: BUS_SEL=5, AR_LD=1. D=8'h04 and I=0 from T3. SC_CLR=1 only at T5. Then T0 again.
- IR=16'hE456 (ISZ indirect) → T3 has BUS_SEL=7, AR_LD=1. SC_CLR is asserted at T6, for 7 cycles total.
- IR=16'h7001 (HLT) → at T3, SC_CLR=1 and RUN falls on that edge. The counter parks at 0 and T=0 thereafter. A later START restarts at T0.
- HLT at T3 with START=1 in the same cycle → RUN=0 after the edge. A START asserted on the following cycle sets RUN=1.
- COUNT forced to 4'hA while RUN=1 → SC_CLR=1, SC_INC=0 that cycle. Also assert reset during T4 of STA → RUN, D and I go to 0 immediately, and T goes to 0.
